// File: rtl/rr_mux_arbiter_pkg.sv
// rr_mux_arbiter_pkg: FSM state encoding and the rotating priority search shared by the arbiter.
package rr_mux_arbiter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
  localparam int MAX_N = 32;
  // First set bit of req at or after start, wrapping mod n; returns start when none is set.
  function automatic int next_pending(input logic [MAX_N-1:0] req, input int start, input int n);
    next_pending = start;
    for (int i = MAX_N - 1; i >= 0; i--)
      if (i < n && req[5'((start + i) % n)]) next_pending = (start + i) % n;
  endfunction
endpackage

// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if: requester-side request/data bundle and the arbiter's grant/mux outputs.
interface rr_mux_arbiter_if #(parameter int N = 4, parameter int W = 1);
  logic [N-1:0] req;
  logic [N*W-1:0] in_data;
  logic [N-1:0] gnt;
  logic [$clog2(N)-1:0] sel;
  logic [W-1:0] out_data;
  logic out_valid;
  modport master (output req, in_data, input gnt, sel, out_data, out_valid);
  modport slave (input req, in_data, output gnt, sel, out_data, out_valid);
endinterface

// File: rtl/rr_mux_arbiter_mux.sv
// mux_nx1: plain combinational N:1 multiplexer of W-bit slices.
module mux_nx1 #(parameter int N = 4, parameter int W = 1) (
  input  logic [N*W-1:0]        data,
  input  logic [$clog2(N)-1:0]  sel,
  output logic [W-1:0]          y
);
  assign y = data[sel*W +: W];
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin grant of one shared N:1 mux output with a MAX_HOLD slot limit.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 1,
  parameter int MAX_HOLD = 4
) (
  input logic clk,
  input logic rst_n,
  rr_mux_arbiter_if.slave bus
);
  localparam int SEL_W = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);
  state_t state, state_nx;
  logic [N-1:0] gnt, others;
  logic [SEL_W-1:0] sel, sel_nx, ptr, ptr_nx, k, idle_k, rot_k;
  logic [HW-1:0] hold, hold_nx;
  logic take, pending;
  logic [W-1:0] mux_out;
  // The current holder is masked out so it never wins its own successor search.
  assign others = bus.req & ~(N'(1) << sel);
  assign pending = |others;
  assign idle_k = SEL_W'(next_pending(MAX_N'(bus.req), int'(ptr), N));
  assign rot_k = SEL_W'(next_pending(MAX_N'(others), (int'(sel) + 1) % N, N));
  always_comb begin
    take = 1'b0;
    k = idle_k;
    state_nx = state;
    sel_nx = sel;
    hold_nx = hold;
    if (state == ST_IDLE) take = |bus.req;
    else if ((!bus.req[sel] || hold == HW'(MAX_HOLD)) && pending) begin
      take = 1'b1;
      k = rot_k;
    end
    else if (!bus.req[sel]) begin
      state_nx = ST_IDLE;
      sel_nx = '0;
    end
    else hold_nx = (hold == HW'(MAX_HOLD)) ? HW'(1) : hold + HW'(1);
    if (take) begin
      state_nx = ST_GRANT;
      sel_nx = k;
      hold_nx = HW'(1);
    end
  end
  assign ptr_nx = take ? k + SEL_W'(1) : ptr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      gnt <= '0;
      sel <= '0;
      ptr <= '0;
      hold <= '0;
    end else begin
      state <= state_nx;
      gnt <= (state_nx == ST_GRANT) ? N'(1) << sel_nx : '0;
      sel <= sel_nx;
      ptr <= ptr_nx;
      hold <= hold_nx;
    end
  end
  mux_nx1 #(.N(N), .W(W)) u_mux (.data(bus.in_data), .sel(sel), .y(mux_out));
  assign bus.gnt = gnt;
  assign bus.sel = sel;
  assign bus.out_valid = |gnt;
  assign bus.out_data = bus.out_valid ? mux_out : '0;
endmodule
